fetch_unit: RTL and testbench

Program-counter and fetch-control stage that sits directly upstream of the instruction memory. The instruction memory has a registered, single-cycle read: an address presented in cycle n yields its word in cycle n+1. This block:
- drives the read address;
- tags each returned word with its PC and a valid bit for decode;
- applies stalls, branch/jump redirects and halt detection;
- counts delivered instructions.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_reg.sv | 50 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions.
// Provides the word/address typedefs used by fetch, decode and the
// instruction memory, the fetch FSM state encoding and the default reset
// PC and halt encoding.
package fetch_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [0:0] {
        FSM_RUN    = 1'b0,
        FSM_HALTED = 1'b1
    } fetch_state_e;

    // The zero word halts fetch, so running off the end of a zero-filled
    // memory stops the stage cleanly.
    localparam word_t HALT_INST_DEFAULT = 32'h0000_0000;
    localparam addr_t RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam addr_t PC_STEP_DEFAULT   = 32'h0000_0001;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register with its next-PC selection.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (pc -> RESET_PC)
//   redirect     - load redirect_pc (highest priority)
//   hold         - keep the current pc
//   redirect_pc  - redirect target (word address)
//   pc           - next address to fetch
// With neither redirect nor hold the pc advances by PC_STEP, wrapping
// modulo 2^32.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT,
    parameter addr_t PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  redirect,
    input  logic  hold,
    input  addr_t redirect_pc,
    output addr_t pc
);

    addr_t pc_r;
    addr_t pc_next_s;

    // Next-PC selection: redirect beats hold, hold beats increment.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect) begin
            pc_next_s = redirect_pc;
        end else if (hold) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_r + PC_STEP;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage in front of a single-cycle registered instruction memory.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   stall           - hold PC and the decode-side instruction
//   redirect_valid  - taken branch/jump; redirect_pc is the target
//   imem_pc         - read address to instruction memory
//   imem_inst       - read data, one cycle after the address
//   id_inst, id_pc  - instruction and its PC presented to decode
//   id_valid        - id_inst/id_pc are live
//   halted          - fetch permanently stopped until reset
//   fetch_count     - instructions delivered (wraps modulo 2^32)
// req_pc/req_valid track the word currently on imem_inst. During a stall
// the memory re-reads req_pc so imem_inst stays stable without a skid
// buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t HALT_INST = HALT_INST_DEFAULT,
    parameter addr_t PC_STEP   = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e fsm_r;
    addr_t        req_pc_r;
    logic         req_valid_r;
    logic         halted_r;
    logic [31:0]  fetch_count_r;

    addr_t pc_s;
    logic  run_s;
    logic  id_valid_s;
    logic  halt_take_s;
    logic  redirect_take_s;
    logic  hold_s;
    logic  deliver_s;

    assign run_s           = (fsm_r == FSM_RUN);
    // A redirect in flight kills whatever word is on imem_inst this cycle.
    assign id_valid_s      = req_valid_r & ~redirect_valid & run_s;
    assign halt_take_s     = id_valid_s & ~stall & (imem_inst == HALT_INST);
    assign redirect_take_s = run_s & redirect_valid;
    assign hold_s          = ~run_s | stall | halt_take_s;
    assign deliver_s       = id_valid_s & ~stall;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect_take_s),
        .hold        (hold_s),
        .redirect_pc (redirect_pc),
        .pc          (pc_s)
    );

    // Request tracking, run/halt FSM and delivered-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r         <= FSM_RUN;
            req_pc_r      <= 32'h0000_0000;
            req_valid_r   <= 1'b0;
            halted_r      <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            case (fsm_r)
                FSM_RUN: begin
                    if (redirect_valid) begin
                        req_valid_r <= 1'b0;
                    end else if (stall) begin
                        req_valid_r <= req_valid_r;
                    end else if (halt_take_s) begin
                        fsm_r       <= FSM_HALTED;
                        req_valid_r <= 1'b0;
                        halted_r    <= 1'b1;
                    end else begin
                        req_pc_r    <= pc_s;
                        req_valid_r <= 1'b1;
                    end
                    if (deliver_s) begin
                        fetch_count_r <= fetch_count_r + 32'h0000_0001;
                    end else begin
                        fetch_count_r <= fetch_count_r;
                    end
                end
                FSM_HALTED: begin
                    req_valid_r <= 1'b0;
                    halted_r    <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park in the safe, quiet state.
                    fsm_r       <= FSM_HALTED;
                    req_valid_r <= 1'b0;
                    halted_r    <= 1'b1;
                end
            endcase
        end
    end

    assign imem_pc     = (stall & req_valid_r) ? req_pc_r : pc_s;
    assign id_pc       = req_pc_r;
    assign id_inst     = imem_inst;
    assign id_valid    = id_valid_s;
    assign halted      = halted_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes the expected
// {id_pc, id_inst} of every instruction that should be delivered; a
// monitor pops and compares on every delivery (id_valid & !stall).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];
    logic [63:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Registered single-cycle instruction memory model (256 words).
    always @(posedge clk) imem_inst <= mem[imem_pc[7:0]];

    // Memory pattern: word i holds (i+1)*0x11, so 0x11, 0x22, 0x33, ...
    function automatic logic [31:0] mv(input int i);
        return 32'((i + 1) * 17);
    endfunction

    // Monitor: compare each delivered instruction against the scoreboard.
    always @(negedge clk) begin
        if (!rst && id_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL delivery unexpected id_pc=%h id_inst=%h", id_pc, id_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({id_pc, id_inst} !== e) begin
                    errors++;
                    $display("FAIL delivery got pc=%h inst=%h expected pc=%h inst=%h",
                             id_pc, id_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // Reset for one cycle, check reset values, release just after an edge.
    task automatic begin_test();
        stall = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_imem_pc", imem_pc, 32'h0000_0000);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        rst = 1'b0;
    endtask

    task automatic end_test(input string name);
        @(negedge clk);
        #1;
        chk(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mv(i);

        // 1: run to halt word at address 3
        mem[3] = 32'h0000_0000;
        push(32'd0, 32'h11); push(32'd1, 32'h22); push(32'd2, 32'h33); push(32'd3, 32'h0);
        begin_test();
        chk("t1_first_bubble", {31'd0, id_valid}, 32'd0);
        step();
        chk("t1_first_valid", {31'd0, id_valid}, 32'd1);
        chk("t1_first_pc", id_pc, 32'd0);
        step(); step(); step();
        step();
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_count", fetch_count, 32'd4);
        chk("t1_imem_pc", imem_pc, 32'd4);
        chk("t1_id_valid", {31'd0, id_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); step();
        redirect_valid = 1'b0;
        chk("t1_halt_terminal", {31'd0, halted}, 32'd1);
        chk("t1_imem_pc_frozen", imem_pc, 32'd4);
        end_test("t1_queue");
        mem[3] = mv(3);

        // 2: three-cycle stall while id_pc=1
        push(32'd0, mv(0)); push(32'd1, mv(1)); push(32'd2, mv(2)); push(32'd3, mv(3));
        begin_test();
        step(); step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_stall_pc", id_pc, 32'd1);
            chk("t2_stall_inst", id_inst, 32'h22);
            chk("t2_stall_imem_pc", imem_pc, 32'd1);
            chk("t2_stall_count", fetch_count, 32'd1);
        end
        stall = 1'b0;
        step(); step();
        end_test("t2_queue");

        // 3: redirect to 0x40 while id_pc=2
        push(32'd0, mv(0)); push(32'd1, mv(1)); push(32'h40, mv(64)); push(32'h41, mv(65));
        begin_test();
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("t3_kill", {31'd0, id_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        chk("t3_bubble", {31'd0, id_valid}, 32'd0);
        chk("t3_imem_pc", imem_pc, 32'h40);
        chk("t3_count", fetch_count, 32'd2);
        step();
        chk("t3_target_pc", id_pc, 32'h40);
        step();
        end_test("t3_queue");

        // 4: redirect and stall together -> redirect wins
        push(32'h20, mv(32)); push(32'h21, mv(33));
        begin_test();
        step();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("t4_bubble", {31'd0, id_valid}, 32'd0);
        chk("t4_imem_pc", imem_pc, 32'h20);
        chk("t4_count", fetch_count, 32'd0);
        step(); step();
        end_test("t4_queue");

        // 5: halt word with a redirect in the same cycle -> no halt
        mem[2] = 32'h0000_0000;
        push(32'd0, mv(0)); push(32'd1, mv(1)); push(32'h30, mv(48)); push(32'h31, mv(49));
        begin_test();
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        step();
        redirect_valid = 1'b0;
        chk("t5_no_halt", {31'd0, halted}, 32'd0);
        step(); step();
        chk("t5_still_running", {31'd0, halted}, 32'd0);
        end_test("t5_queue");
        mem[2] = mv(2);

        // 7: PC wrap from 0xFFFF_FFFF to 0
        push(32'hFFFF_FFFF, mv(255)); push(32'd0, mv(0));
        begin_test();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        step(); step();
        end_test("t7_queue");

        // 6: asynchronous reset between edges, during a stall
        push(32'd0, mv(0));
        begin_test();
        step(); step();
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, id_valid}, 32'd0);
        chk("t6_async_imem_pc", imem_pc, 32'd0);
        chk("t6_async_count", fetch_count, 32'd0);
        chk("t6_async_halted", {31'd0, halted}, 32'd0);
        chk("t6_pre_queue", exp_q.size(), 32'd0);
        stall = 1'b0;
        step();
        rst = 1'b0;
        push(32'd0, mv(0)); push(32'd1, mv(1)); push(32'd2, mv(2));
        step(); step(); step();
        end_test("t6_queue");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
